uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 87, clocks per serial bit (10 MHz clk, 115200 baud); legal range 2..65535.
REQ-002 SHALL have parameter: FIFO_DEPTH, 4, byte buffer entries; power of two, minimum 2.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: TxEn  input  1  byte-valid strobe from the CPU-side data filter; one byte per high cycle.
REQ-006 SHALL have port: TxData  input  8  byte to send; sampled when TxEn is high.
REQ-007 SHALL have port: Tx  output  1  serial line; idle high.
REQ-008 SHALL have port: TxBusy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-009 SHALL have port: TxDone  output  1  one-cycle pulse at the end of each stop bit.
REQ-010 SHALL have port: TxOverflow  output  1  one-cycle pulse when a byte is dropped because the FIFO is full.

Function
REQ-011 SHALL push TxData into the FIFO on every clock where TxEn=1 and the FIFO is not full.
REQ-012 SHALL accept a push in a cycle where the FIFO is full and a pop occurs in the same cycle; otherwise a push to a full FIFO drops the byte and pulses TxOverflow on the next cycle.
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START when the FIFO is non-empty, popping the head byte into a shift register.
REQ-014 SHALL hold Tx=0 for CLKS_PER_BIT clocks in START, then send 8 data bits LSB first, each for CLKS_PER_BIT clocks, then STOP with Tx=1 for CLKS_PER_BIT clocks.
REQ-015 SHALL drive Tx from a register; when idle with an empty FIFO, Tx falls exactly 2 clocks after the edge that samples TxEn.
REQ-016 SHALL go STOP->START with no idle gap when the FIFO is non-empty at the end of the stop bit, and STOP->IDLE otherwise.
REQ-017 SHALL pulse TxDone in the last clock of the stop bit, once per frame.
REQ-018 SHALL keep the bit counter at 3 bits and the baud counter at $clog2(CLKS_PER_BIT) bits; the baud counter wraps to 0 at CLKS_PER_BIT-1.
REQ-019 SHALL never change the frame in flight because of new TxEn input.

Reset
REQ-020 SHALL, while reset=1, immediately force Tx=1, TxBusy=0, TxDone=0, TxOverflow=0, FSM=IDLE, FIFO empty, and all counters 0.
REQ-021 SHALL discard a partially sent frame and all buffered bytes when reset is asserted mid-frame; after release the line stays idle until the next TxEn.
REQ-022 SHALL ignore TxEn while reset=1.

Configuration
REQ-023 SHALL, when UART_TX_PARITY_EN is defined, send one even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT clocks in state PARITY, between DATA and STOP.
REQ-024 SHALL, when UART_TX_PARITY_EN is undefined, omit the PARITY state and go DATA->STOP, giving a 10-bit frame.

Structure
REQ-025 SHALL take the FSM state enum, the idle line level and the data width (8) from shared package uart_pkg.
REQ-026 SHALL place the byte buffer in sub-module uart_tx_fifo (synchronous write/read, full/empty flags, depth from FIFO_DEPTH).

Verification
REQ-027 SHALL verify: CLKS_PER_BIT=4, no parity, TxEn with 0x12 -> Tx sequence 0,0,1,0,0,1,0,0,0,1, each bit for 4 clocks; one TxDone pulse; TxBusy low after it.
REQ-028 SHALL verify: CLKS_PER_BIT=4, UART_TX_PARITY_EN, byte 0x07 -> parity bit 1; byte 0x12 -> parity bit 0; frame is 11 bits long.
REQ-029 SHALL verify: bytes 0x12 then 0x34 on consecutive cycles -> two frames separated by no idle gap; TxDone pulses 40 clocks apart (10-bit frame at 4 clocks per bit).
REQ-030 SHALL verify: FIFO_DEPTH=4, 6 bytes 0x01..0x06 on consecutive cycles while idle -> 0x01..0x05 are sent in order (0x01 in flight, 4 buffered); 0x06 is dropped with exactly one TxOverflow pulse.
REQ-031 SHALL verify: reset asserted during bit 3 of 0x55 -> Tx=1 in the same cycle, TxBusy=0, no TxDone; the next byte 0xA5 is sent as a clean full frame.
REQ-032 SHALL verify: default CLKS_PER_BIT=87 at 10 MHz clk -> start bit lasts exactly 8700 ns.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, idle line level and data width.
package uart_pkg;

  localparam int   DATA_W    = 8;
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; head byte is visible on o_rd_data while not empty.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_pop     = i_rd_en && !o_empty;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign w_push    = i_wr_en && (!o_full || w_pop);
  assign o_rd_data = r_mem[r_rd_ptr];

  // NOTE: storage is deliberately not reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with byte FIFO: 8N1 frames, or 8E1 when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              TxEn,
  input  logic [DATA_W-1:0] TxData,
  output logic              Tx,
  output logic              TxBusy,
  output logic              TxDone,
  output logic              TxOverflow
);

  localparam int            BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_e         r_state;
  tx_state_e         w_state_nxt;
  logic [BW-1:0]     r_baud;
  logic [2:0]        r_bit;
  logic [DATA_W-1:0] r_shift;
  logic              r_tx;
  logic              r_busy;
  logic              r_done;
  logic              r_ovf;
  logic              w_tx_nxt;
  logic              w_done_nxt;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_bit_end;
  logic [DATA_W-1:0] w_head;
`ifdef UART_TX_PARITY_EN
  logic              r_parity;
`endif

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (TxEn),
    .i_wr_data (TxData),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign w_bit_end = (r_baud == BAUD_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tx_nxt    = LINE_IDLE;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = ST_START;
          w_pop       = 1'b1;
        end
      end
      ST_START: begin
        w_tx_nxt = 1'b0;
        if (w_bit_end) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        w_tx_nxt = r_shift[0];
        if (w_bit_end && r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          w_state_nxt = ST_PARITY;
`else
          w_state_nxt = ST_STOP;
`endif
        end
      end
      ST_PARITY: begin
`ifdef UART_TX_PARITY_EN
        w_tx_nxt = r_parity;
        if (w_bit_end) w_state_nxt = ST_STOP;
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      ST_STOP: begin
        w_tx_nxt = LINE_IDLE;
        if (w_bit_end) begin
          w_done_nxt = 1'b1;
          // Chain straight into the next start bit when another byte is waiting.
          if (!w_empty) begin
            w_state_nxt = ST_START;
            w_pop       = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      if (r_state == ST_IDLE || w_bit_end) r_baud <= '0;
      else                                 r_baud <= r_baud + 1'b1;
      if (w_pop)                                r_shift <= w_head;
      else if (r_state == ST_DATA && w_bit_end) r_shift <= {1'b0, r_shift[DATA_W-1:1]};
      if (r_state == ST_DATA && w_bit_end) r_bit <= r_bit + 1'b1;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_parity <= 1'b0;
    else if (w_pop) r_parity <= even_parity(w_head);
  end
`endif

  // Line and status are registered, so they trail the FSM state by one clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx   <= LINE_IDLE;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_tx   <= w_tx_nxt;
      r_busy <= (r_state != ST_IDLE) || !w_empty;
      r_done <= w_done_nxt;
      r_ovf  <= TxEn && w_full && !w_pop;
    end
  end

  assign Tx         = r_tx;
  assign TxBusy     = r_busy;
  assign TxDone     = r_done;
  assign TxOverflow = r_ovf;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a line monitor decodes frames and checks them against a byte scoreboard.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int  CPB        = 4;
  localparam time CLK_PERIOD = 100;
`ifdef UART_TX_PARITY_EN
  localparam int  FRAME_BITS = 11;
`else
  localparam int  FRAME_BITS = 10;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       TxEn;
  logic [7:0] TxData;
  logic       Tx, TxBusy, TxDone, TxOverflow;
  logic       TxEn_d;
  logic [7:0] TxData_d;
  logic       Tx_d, TxBusy_d, TxDone_d, TxOverflow_d;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   rx_count = 0;
  int   done_cnt = 0;
  int   ovf_cnt  = 0;
  logic [7:0] exp_q[$];
  time  done_times[$];

  always #(CLK_PERIOD / 2) clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .TxEn       (TxEn),
    .TxData     (TxData),
    .Tx         (Tx),
    .TxBusy     (TxBusy),
    .TxDone     (TxDone),
    .TxOverflow (TxOverflow)
  );

  uart_tx dut_def (
    .clk        (clk),
    .reset      (reset),
    .TxEn       (TxEn_d),
    .TxData     (TxData_d),
    .Tx         (Tx_d),
    .TxBusy     (TxBusy_d),
    .TxDone     (TxDone_d),
    .TxOverflow (TxOverflow_d)
  );

  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, d, 1'b0};
`endif
  endfunction

  // Line monitor: every bit must hold CPB clocks; TxDone only in the final stop-bit clock.
  always begin : line_monitor
    logic [FRAME_BITS-1:0] got;
    logic [FRAME_BITS-1:0] exp_f;
    logic [7:0]            exp_b;
    bit                    glitch;
    bit                    done_bad;
    bit                    aborted;
    @(negedge clk);
    if (reset === 1'b0 && Tx === 1'b0) begin
      got      = '0;
      glitch   = 1'b0;
      done_bad = 1'b0;
      aborted  = 1'b0;
      for (int b = 0; b < FRAME_BITS && !aborted; b++) begin
        for (int c = 0; c < CPB && !aborted; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (reset !== 1'b0) begin
            aborted = 1'b1;
          end else begin
            if (c == 0) got[b] = Tx;
            else if (Tx !== got[b]) glitch = 1'b1;
            if (TxDone !== ((b == FRAME_BITS - 1) && (c == CPB - 1))) done_bad = 1'b1;
          end
        end
      end
      if (!aborted) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rx_frame: got frame %b, expected no frame", got);
        end else begin
          exp_b = exp_q.pop_front();
          exp_f = make_frame(exp_b);
          if (got !== exp_f) begin
            n_fail++;
            $display("FAIL rx_frame: got %b, expected %b (byte %h)", got, exp_f, exp_b);
          end
        end
        n_checks++;
        if (glitch || done_bad) begin
          n_fail++;
          $display("FAIL frame_timing: glitch=%0b done_misplaced=%0b, expected 0 0", glitch, done_bad);
        end
        rx_count++;
      end
    end
  end

  always @(negedge clk) begin
    if (TxDone === 1'b1) begin
      done_cnt++;
      done_times.push_back($time);
    end
    if (TxOverflow === 1'b1) ovf_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int left;
    left = budget;
    while (rx_count < target && left > 0) begin
      tick();
      left--;
    end
    n_checks++;
    if (rx_count < target) begin
      n_fail++;
      $display("FAIL frame_wait: received %0d frames, expected %0d", rx_count, target);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    TxEn     = 1'b1;
    TxData   = 8'hA5;
    TxEn_d   = 1'b0;
    TxData_d = 8'h00;
    repeat (3) tick();
    n_checks++;
    if ({Tx, TxBusy, TxDone, TxOverflow} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_outputs: Tx/Busy/Done/Ovf=%b, expected 1000", {Tx, TxBusy, TxDone, TxOverflow});
    end
    n_checks++;
    if (Tx_d !== 1'b1 || TxBusy_d !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_default_inst: Tx=%b Busy=%b, expected 1 0", Tx_d, TxBusy_d);
    end
    TxEn  = 1'b0;
    reset = 1'b0;
    repeat (10) tick();
    n_checks++;
    if (Tx !== 1'b1 || TxBusy !== 1'b0 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL reset_txen_ignored: Tx=%b Busy=%b dones=%0d, expected 1 0 0", Tx, TxBusy, done_cnt);
    end
  endtask

  task automatic test_single();
    int base_done;
    base_done = done_cnt;
    tick();
    TxEn   = 1'b1;
    TxData = 8'h12;
    exp_q.push_back(8'h12);
    tick();
    TxEn = 1'b0;
    tick();
    n_checks++;
    if (Tx !== 1'b1) begin
      n_fail++;
      $display("FAIL tx_latency_1clk: Tx=%b, expected 1", Tx);
    end
    tick();
    n_checks++;
    if (Tx !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_latency_2clk: Tx=%b, expected 0", Tx);
    end
    wait_frames(rx_count + 1, 60);
    tick();
    n_checks++;
    if (TxBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_after_done: TxBusy=%b, expected 0", TxBusy);
    end
    n_checks++;
    if (done_cnt - base_done != 1) begin
      n_fail++;
      $display("FAIL done_count_single: %0d pulses, expected 1", done_cnt - base_done);
    end
  endtask

  task automatic test_parity();
    logic [7:0] bytes [2];
    bytes[0] = 8'h07;
    bytes[1] = 8'h12;
    for (int i = 0; i < 2; i++) begin
      tick();
      TxEn   = 1'b1;
      TxData = bytes[i];
      exp_q.push_back(bytes[i]);
      tick();
      TxEn = 1'b0;
      wait_frames(rx_count + 1, FRAME_BITS * CPB + 20);
      repeat (3) tick();
    end
  endtask

  task automatic test_back_to_back();
    int  base_done;
    time gap;
    base_done = done_cnt;
    tick();
    TxEn   = 1'b1;
    TxData = 8'h12;
    exp_q.push_back(8'h12);
    tick();
    TxData = 8'h34;
    exp_q.push_back(8'h34);
    tick();
    TxEn = 1'b0;
    wait_frames(rx_count + 2, 2 * FRAME_BITS * CPB + 20);
    repeat (2) tick();
    n_checks++;
    if (done_cnt - base_done != 2) begin
      n_fail++;
      $display("FAIL done_count_b2b: %0d pulses, expected 2", done_cnt - base_done);
    end else begin
      gap = done_times[done_times.size() - 1] - done_times[done_times.size() - 2];
      n_checks++;
      if (gap != FRAME_BITS * CPB * CLK_PERIOD) begin
        n_fail++;
        $display("FAIL done_spacing: %0t apart, expected %0t", gap, FRAME_BITS * CPB * CLK_PERIOD);
      end
    end
  endtask

  task automatic test_overflow();
    int base_ovf;
    int base_rx;
    base_ovf = ovf_cnt;
    base_rx  = rx_count;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 6) begin
        n_checks++;
        if (TxOverflow !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_early: TxOverflow=%b, expected 0", TxOverflow);
        end
      end
      TxEn   = 1'b1;
      TxData = 8'(i);
      if (i <= 5) exp_q.push_back(8'(i));
    end
    tick();
    TxEn = 1'b0;
    n_checks++;
    if (TxOverflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_pulse: TxOverflow=%b, expected 1", TxOverflow);
    end
    wait_frames(base_rx + 5, 5 * FRAME_BITS * CPB + 40);
    repeat (5) tick();
    n_checks++;
    if (ovf_cnt - base_ovf != 1 || rx_count - base_rx != 5) begin
      n_fail++;
      $display("FAIL ovf_totals: %0d overflow pulses %0d frames, expected 1 5",
               ovf_cnt - base_ovf, rx_count - base_rx);
    end
  endtask

  task automatic test_reset_mid_frame();
    int  base_done;
    int  left;
    bit  idle_bad;
    base_done = done_cnt;
    tick();
    TxEn   = 1'b1;
    TxData = 8'h55;
    tick();
    TxEn = 1'b0;
    left = 10;
    while (Tx !== 1'b0 && left > 0) begin
      tick();
      left--;
    end
    n_checks++;
    if (Tx !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_start: Tx=%b, expected 0", Tx);
    end
    repeat (17) tick();
    #10 reset = 1'b1;
    #1;
    n_checks++;
    if (Tx !== 1'b1 || TxBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_immediate: Tx=%b Busy=%b, expected 1 0", Tx, TxBusy);
    end
    repeat (2) tick();
    reset    = 1'b0;
    idle_bad = 1'b0;
    repeat (20) begin
      tick();
      if (Tx !== 1'b1 || TxBusy !== 1'b0) idle_bad = 1'b1;
    end
    n_checks++;
    if (idle_bad || done_cnt != base_done) begin
      n_fail++;
      $display("FAIL midreset_idle: line_not_idle=%0b dones=%0d, expected 0 0", idle_bad, done_cnt - base_done);
    end
    tick();
    TxEn   = 1'b1;
    TxData = 8'hA5;
    exp_q.push_back(8'hA5);
    tick();
    TxEn = 1'b0;
    wait_frames(rx_count + 1, FRAME_BITS * CPB + 20);
    repeat (3) tick();
  endtask

  task automatic test_default_baud();
    int  left;
    time t0;
    time t1;
    tick();
    TxEn_d   = 1'b1;
    TxData_d = 8'hFF;
    tick();
    TxEn_d = 1'b0;
    left   = 10;
    while (Tx_d !== 1'b0 && left > 0) begin
      tick();
      left--;
    end
    t0   = $time;
    left = 200;
    while (Tx_d === 1'b0 && left > 0) begin
      tick();
      left--;
    end
    t1 = $time;
    n_checks++;
    if (t1 - t0 != 8700) begin
      n_fail++;
      $display("FAIL default_start_bit: lasted %0t, expected 8700 ns", t1 - t0);
    end
    left = 1200;
    while (TxBusy_d !== 1'b0 && left > 0) begin
      tick();
      left--;
    end
    n_checks++;
    if (TxBusy_d !== 1'b0 || Tx_d !== 1'b1) begin
      n_fail++;
      $display("FAIL default_frame_end: Busy=%b Tx=%b, expected 0 1", TxBusy_d, Tx_d);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_default_baud();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d bytes never sent, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
